// File: rtl/pwm_detect_multi_pkg.sv
// Shared definitions for the multi-channel PWM high/low interval detector.
// Holds default parameter values, the simulation clock period used by
// benches, and the per-channel state encoding exposed on the debug bus.
package pwm_detect_multi_pkg;

  localparam int DEF_NUM_CH      = 3;
  localparam int DEF_CNT_WIDTH   = 32;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 100000000;  // 1 s at 100 MHz

  localparam int CLK_PERIOD = 10;  // ns, 100 MHz

  // Per-channel tracking state:
  //   CH_IDLE      no edge seen since reset/enable (level length unknown)
  //   CH_ARMED     edges seen, no complete high interval held yet
  //   CH_HAVE_HIGH a complete high interval is held; next rise emits a sample
  //   CH_STUCK     no edge for TIMEOUT cycles
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    CH_IDLE      = 2'd0,
    CH_ARMED     = 2'd1,
    CH_HAVE_HIGH = 2'd2,
    CH_STUCK     = 2'd3
  } chan_state_e;

endpackage

// File: rtl/pwm_detect_multi_if.sv
// Bundle of per-channel PWM inputs and measurement outputs.
//   enable       per-channel enable (low holds the channel in reset)
//   pwm          asynchronous PWM inputs, bit i = channel i
//   high_count   last complete high interval, ch i at [i*CNT_WIDTH +: CNT_WIDTH]
//   low_count    last complete low interval, same packing
//   sample_valid one-cycle strobe per channel
//   stuck        per-channel level, no edge for TIMEOUT cycles
//   dbg_state    per-channel chan_state_e, ch i at [i*STATE_W +: STATE_W]
// Handshake: sample_valid[i] qualifies the high/low pair of channel i for
// exactly one cycle. There is no ready; the consumer takes the pair on the
// pulse (the counts also hold until the next update).
interface pwm_detect_multi_if
  import pwm_detect_multi_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
  logic [NUM_CH-1:0]           enable;
  logic [NUM_CH-1:0]           pwm;
  logic [NUM_CH*CNT_WIDTH-1:0] high_count;
  logic [NUM_CH*CNT_WIDTH-1:0] low_count;
  logic [NUM_CH-1:0]           sample_valid;
  logic [NUM_CH-1:0]           stuck;
  logic [NUM_CH*STATE_W-1:0]   dbg_state;

  modport master (
    output enable, pwm,
    input  high_count, low_count, sample_valid, stuck, dbg_state
  );

  modport slave (
    input  enable, pwm,
    output high_count, low_count, sample_valid, stuck, dbg_state
  );
endinterface

// File: rtl/pwm_detect_chan.sv
// One PWM measurement channel: synchroniser, edge detect, level counter,
// tracking FSM and registered interval outputs.
//   clock, reset      system clock, synchronous active-high reset
//   i_enable          low holds this channel in its reset state
//   i_pwm             asynchronous PWM input
//   o_high_count      last complete high interval (cycles)
//   o_low_count       last complete low interval (cycles)
//   o_sample_valid    one-cycle pulse when a new high+low pair is latched
//   o_stuck           no edge for TIMEOUT cycles
//   o_state           current tracking state (debug)
module pwm_detect_chan
  import pwm_detect_multi_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic                 i_pwm,
  output logic [CNT_WIDTH-1:0] o_high_count,
  output logic [CNT_WIDTH-1:0] o_low_count,
  output logic                 o_sample_valid,
  output logic                 o_stuck,
  output chan_state_e          o_state
);

  localparam logic [CNT_WIDTH-1:0] TO_VAL  = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [CNT_WIDTH-1:0]   r_counter;
  logic [CNT_WIDTH-1:0]   r_high;
  logic [CNT_WIDTH-1:0]   r_low;
  logic                   r_valid;
  chan_state_e            r_state;
  chan_state_e            w_state_nxt;

  logic w_rst;
  logic w_s;
  logic w_rise;
  logic w_fall;
  logic w_edge;
  logic w_at_timeout;
  logic w_latch_high;
  logic w_latch_low;
  logic w_pulse;
  logic w_enter_stuck;

  // A disabled channel behaves exactly as if held in reset.
  assign w_rst        = reset | ~i_enable;
  assign w_s          = r_sync[SYNC_STAGES-1];
  assign w_rise       = w_s & ~r_s_d;
  assign w_fall       = ~w_s & r_s_d;
  assign w_edge       = w_rise | w_fall;
  assign w_at_timeout = (r_counter == TO_VAL);

  always_ff @(posedge clock) begin
    if (w_rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm};
      r_s_d  <= w_s;
    end
  end

  // Counter holds the length of the current level; it restarts at 1 on the
  // edge that begins the level and saturates at TIMEOUT.
  always_ff @(posedge clock) begin
    if (w_rst) begin
      r_counter <= '0;
    end else if (w_edge) begin
      r_counter <= CNT_ONE;
    end else if (!w_at_timeout) begin
      r_counter <= r_counter + CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (w_rst) begin
      r_state <= CH_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Edges take priority over the timeout check: a level that ends exactly
  // as the counter saturates is still measured normally.
  always_comb begin
    w_state_nxt   = r_state;
    w_latch_high  = 1'b0;
    w_latch_low   = 1'b0;
    w_pulse       = 1'b0;
    w_enter_stuck = 1'b0;
    case (r_state)
      CH_IDLE: begin
        // The level before the first edge has unknown length; never report it.
        if (w_edge) begin
          w_state_nxt = CH_ARMED;
        end else if (w_at_timeout) begin
          w_state_nxt   = CH_STUCK;
          w_enter_stuck = 1'b1;
        end
      end
      CH_ARMED: begin
        if (w_fall) begin
          w_latch_high = 1'b1;
          w_state_nxt  = CH_HAVE_HIGH;
        end else if (w_rise) begin
          w_latch_low = 1'b1;
        end else if (w_at_timeout) begin
          w_state_nxt   = CH_STUCK;
          w_enter_stuck = 1'b1;
        end
      end
      CH_HAVE_HIGH: begin
        if (w_fall) begin
          w_latch_high = 1'b1;
        end else if (w_rise) begin
          w_latch_low = 1'b1;
          w_pulse     = 1'b1;
        end else if (w_at_timeout) begin
          w_state_nxt   = CH_STUCK;
          w_enter_stuck = 1'b1;
        end
      end
      CH_STUCK: begin
        // The exit edge only restarts measurement; the timed-out level is
        // discarded and a fresh high must be seen before the next sample.
        if (w_edge) begin
          w_state_nxt = CH_ARMED;
        end
      end
      default: begin
        w_state_nxt = CH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_rst) begin
      r_high  <= '0;
      r_low   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_pulse;
      if (w_latch_high) begin
        r_high <= r_counter;
      end
      if (w_latch_low) begin
        r_low <= r_counter;
      end
      if (w_enter_stuck) begin
        if (w_s) begin
          r_high <= TO_VAL;
          r_low  <= '0;
        end else begin
          r_high <= '0;
          r_low  <= TO_VAL;
        end
      end
    end
  end

  assign o_high_count   = r_high;
  assign o_low_count    = r_low;
  assign o_sample_valid = r_valid;
  assign o_stuck        = (r_state == CH_STUCK);
  assign o_state        = r_state;

endmodule

// File: rtl/pwm_detect_multi.sv
// N-channel PWM high/low interval detector. Each channel is an independent
// pwm_detect_chan; this level only slices the packed buses.
//   clock  100 MHz system clock
//   reset  synchronous, active-high
//   bus    pwm_detect_multi_if slave: enable/pwm in, counts/strobes/stuck out
module pwm_detect_multi
  import pwm_detect_multi_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset,
  pwm_detect_multi_if.slave  bus
);

  logic [CNT_WIDTH-1:0] w_high  [NUM_CH];
  logic [CNT_WIDTH-1:0] w_low   [NUM_CH];
  chan_state_e          w_state [NUM_CH];
  logic [NUM_CH-1:0]    w_valid;
  logic [NUM_CH-1:0]    w_stuck;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_detect_chan #(
      .CNT_WIDTH   (CNT_WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT)
    ) u_chan (
      .clock          (clock),
      .reset          (reset),
      .i_enable       (bus.enable[i]),
      .i_pwm          (bus.pwm[i]),
      .o_high_count   (w_high[i]),
      .o_low_count    (w_low[i]),
      .o_sample_valid (w_valid[i]),
      .o_stuck        (w_stuck[i]),
      .o_state        (w_state[i])
    );

    assign bus.high_count[i*CNT_WIDTH +: CNT_WIDTH] = w_high[i];
    assign bus.low_count[i*CNT_WIDTH +: CNT_WIDTH]  = w_low[i];
    assign bus.dbg_state[i*STATE_W +: STATE_W]      = w_state[i];
  end

  assign bus.sample_valid = w_valid;
  assign bus.stuck        = w_stuck;

endmodule
